lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Initiator side of the core's simple valid/ready peripheral bus. CLINT and the other memory-mapped slaves are the responders on this bus.
- Accepts one load/store at a time from the MEM stage and drives a single registered bus transaction, holding it until the responder is ready.
- Performs byte-lane alignment, size masking, sign/zero extension, timeout and error reporting.
- Returns a one-cycle completion pulse to the pipeline.

Parameters:
- DATA_W, 64, bus data width in bits (matches `DATA_BUS_SIZE).
- ADDR_W, 64, bus address width in bits.
- TIMEOUT, 255, maximum REQ cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- lsu_req_valid  in  1  pipeline request strobe
- lsu_req_ready  out  1  high only in IDLE
- lsu_we  in  1  1 = store, 0 = load
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 dword
- lsu_unsigned  in  1  zero-extend loads when 1
- lsu_addr  in  ADDR_W  byte address
- lsu_wdata  in  DATA_W  store data, LSB-justified
- lsu_flush  in  1  kill the outstanding result
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  DATA_W  extended load result, valid with lsu_done
- lsu_err  out  2  00 ok, 01 bus error, 10 timeout, 11 misaligned
- bus_valid  out  1  request valid
- bus_addr  out  ADDR_W  unmodified byte address
- bus_size  out  2  copy of lsu_size
- bus_req  out  1  `REQ_READ / `REQ_WRITE
- bus_data_write  out  DATA_W  lane-shifted store data
- bus_ready  in  1  responder ready; may be combinational, same cycle as valid
- bus_data_read  in  DATA_W  raw read data, valid when bus_valid & bus_ready
- bus_resp  in  2  nonzero = error

Behaviour:
- Reset (async, any state): state=IDLE; bus_valid=0, bus_addr=0, bus_size=0, bus_req=`REQ_READ, bus_data_write=0; lsu_done=0, lsu_rdata=0, lsu_err=00; timeout counter=0; kill flag=0.
- FSM has three states: IDLE, REQ, RESP.
- IDLE, acceptance: on lsu_req_valid the request is latched.
- IDLE, aligned request:
  - Registers are loaded: bus_addr=lsu_addr, bus_size, bus_req from lsu_we, bus_data_write = lsu_wdata << (8*addr[2:0]).
  - The FSM goes to REQ, so bus_valid rises one cycle after acceptance.
- IDLE, misaligned request (addr[0] for half, addr[1:0] for word, addr[2:0] for dword nonzero):
  - No bus activity.
  - The FSM goes to RESP with lsu_err=11 and lsu_rdata=0.
- REQ:
  - bus_valid=1 and all bus_* outputs are held stable.
  - The counter increments every cycle bus_ready=0.
  - On bus_ready=1 the transaction completes: read data is captured and the FSM goes to RESP. lsu_err=01 if bus_resp!=0, else 00.
- REQ, read-data formatting: shift bus_data_read right by 8*addr[2:0], mask to the size, then sign-extend (or zero-extend if lsu_unsigned). Dword loads pass through unchanged.
- REQ, stores: lsu_rdata=0.
- REQ, timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT with no ready, bus_valid drops, lsu_err=10 and the FSM goes to RESP.
- REQ, completion priority: if ready arrives in the same cycle as the timeout, completion wins.
- RESP:
  - lsu_done=1 for exactly one cycle unless the kill flag is set.
  - The FSM then returns to IDLE and the counter and kill flag clear.
  - lsu_rdata and lsu_err hold their values until the next RESP.
- Zero-wait responder: accept at cycle 0, bus_valid at cycle 1, lsu_done at cycle 2. Minimum accept-to-done latency is 2 cycles.
- Flush:
  - In IDLE: ignored. A simultaneous lsu_req_valid is still accepted.
  - In REQ: sets the kill flag. The bus transaction still runs to completion or timeout, because it cannot be aborted, and lsu_done is suppressed.
  - In RESP: lsu_done is suppressed that cycle.
- Back-to-back: lsu_req_ready is low in REQ and RESP. The next request can be accepted the cycle after RESP.

Decomposition:
- defines.v holds `REQ_READ (1'b0), `REQ_WRITE (1'b1), the size encodings, the lsu_err codes and the FSM state encodings.
- One natural sub-module, lsu_data_align: the combinational store lane-shift and the load extract/extend. It is reusable by a future AXI bridge.

Test Plan:
- Store dword 0x0000_0000_0000_0100 to `MTIMECMP_ADDR, zero-wait CLINT responder:
  - bus_valid high exactly 1 cycle.
  - lsu_done at accept+2, lsu_err=00.
  - A later dword load of the same address returns 0x100.
- Signed byte load, addr offset 3, bus_data_read=0x0000_0000_8000_0000:
  - Returns lsu_rdata=0xFFFF_FFFF_FFFF_FF80.
  - With lsu_unsigned=1 returns 0x80.
- Responder asserts ready 3 cycles after valid:
  - bus_addr, bus_size, bus_req and bus_data_write remain constant throughout.
  - lsu_done at accept+5.
- TIMEOUT=4, responder never ready:
  - bus_valid drops after 4 cycles and lsu_err=10.
  - Second variant: ready in the same cycle as the timeout gives lsu_err=00.
- Half load at addr 0x...1:
  - No bus_valid.
  - lsu_done at accept+1 with lsu_err=11.
- Flush during REQ, then async rst mid-REQ:
  - First case: the transaction completes on the bus and no lsu_done is seen.
  - Second case: bus_valid falls immediately without waiting for clk, and the FSM is in IDLE with lsu_req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_bus_master_pkg.sv
// Shared encodings for the LSU bus initiator:
// request kinds, access sizes, error codes and FSM states.
package lsu_bus_master_pkg;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_BUS = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_MIS = 2'b11;

  localparam logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic m;
    m = 1'b0;
    unique case (size)
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      SZ_D:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering: store data shifted onto its lanes,
// load data pulled down, masked to size and extended.
module lsu_data_align
  import lsu_bus_master_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [2:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_lane,
  input  logic [2:0]        ld_off,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] ld_ext
);

  logic [DATA_W-1:0] sh;
  logic sx;

  assign st_lane = st_data << {st_off, 3'b000};
  assign sx = ~uns;

  always_comb begin
    sh = ld_raw >> {ld_off, 3'b000};
    ld_ext = sh;
    unique case (size)
      SZ_B: ld_ext = {{(DATA_W-8){sx & sh[7]}}, sh[7:0]};
      SZ_H: ld_ext = {{(DATA_W-16){sx & sh[15]}}, sh[15:0]};
      SZ_W: ld_ext = {{(DATA_W-32){sx & sh[31]}}, sh[31:0]};
      default: ld_ext = sh;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store initiator for the core's
// valid/ready peripheral bus (CLINT and friends respond).
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_unsigned,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic              lsu_flush,
  output logic              lsu_done,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_err,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_size,
  output logic              bus_req,
  output logic [DATA_W-1:0] bus_data_write,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_data_read,
  input  logic [1:0]        bus_resp
);

  localparam int CW = $clog2(TIMEOUT + 2);

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic kill, uns_q;
  logic accept, misal, tmo;
  logic [DATA_W-1:0] st_lane, ld_ext;

  assign lsu_req_ready = (state == S_IDLE);
  assign bus_valid = (state == S_REQ);
  assign accept = lsu_req_ready & lsu_req_valid;
  assign misal = misaligned(lsu_size, lsu_addr[2:0]);
  assign tmo = (TIMEOUT != 0) && !bus_ready
            && (cnt == CW'(TIMEOUT - 1));

  lsu_data_align #(.DATA_W(DATA_W)) u_align (
    .size    (bus_size),
    .uns     (uns_q),
    .st_off  (lsu_addr[2:0]),
    .st_data (lsu_wdata),
    .st_lane (st_lane),
    .ld_off  (bus_addr[2:0]),
    .ld_raw  (bus_data_read),
    .ld_ext  (ld_ext)
  );

  always_comb begin
    state_nx = state;
    lsu_done = 1'b0;
    unique case (state)
      S_IDLE: if (accept) state_nx = misal ? S_RESP : S_REQ;
      S_REQ:  if (bus_ready || tmo) state_nx = S_RESP;
      S_RESP: begin
        lsu_done = !kill && !lsu_flush;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr       <= '0;
      bus_size       <= SZ_B;
      bus_req        <= REQ_READ;
      bus_data_write <= '0;
      lsu_rdata      <= '0;
      lsu_err        <= ERR_OK;
      cnt            <= '0;
      kill           <= 1'b0;
      uns_q          <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          if (misal) begin
            lsu_err   <= ERR_MIS;
            lsu_rdata <= '0;
          end else begin
            bus_addr       <= lsu_addr;
            bus_size       <= lsu_size;
            bus_req        <= lsu_we;
            bus_data_write <= st_lane;
            uns_q          <= lsu_unsigned;
          end
        end
        S_REQ: begin
          if (lsu_flush) kill <= 1'b1;
          if (bus_ready) begin
            lsu_err   <= (|bus_resp) ? ERR_BUS : ERR_OK;
            lsu_rdata <= (bus_req == REQ_WRITE) ? '0 : ld_ext;
          end else if (tmo) begin
            lsu_err   <= ERR_TMO;
            lsu_rdata <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          cnt  <= '0;
          kill <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master with a behavioural
// responder (programmable wait states, error code, memory).
module tb_lsu_bus_master;
  import lsu_bus_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic        lsu_we = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic        lsu_unsigned = 1'b0;
  logic [63:0] lsu_addr = '0;
  logic [63:0] lsu_wdata = '0;
  logic        lsu_flush = 1'b0;
  logic        lsu_done;
  logic [63:0] lsu_rdata;
  logic [1:0]  lsu_err;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [1:0]  bus_size;
  logic        bus_req;
  logic [63:0] bus_data_write;
  logic        bus_ready;
  logic [63:0] bus_data_read;
  logic [1:0]  bus_resp;

  lsu_bus_master #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_we         (lsu_we),
    .lsu_size       (lsu_size),
    .lsu_unsigned   (lsu_unsigned),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_flush      (lsu_flush),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .lsu_err        (lsu_err),
    .bus_valid      (bus_valid),
    .bus_addr       (bus_addr),
    .bus_size       (bus_size),
    .bus_req        (bus_req),
    .bus_data_write (bus_data_write),
    .bus_ready      (bus_ready),
    .bus_data_read  (bus_data_read),
    .bus_resp       (bus_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int acc = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic [1:0]  err;
  } exp_t;
  exp_t sb[$];

  // responder model
  int          lat = 0;
  bit          never = 1'b0;
  bit          use_force = 1'b0;
  logic [63:0] force_data = '0;
  logic [1:0]  resp_code = 2'b00;
  int          wcnt;
  logic [63:0] mem [16];
  logic [63:0] wmask;

  assign bus_ready = bus_valid && !never && (wcnt >= lat);
  assign bus_resp = resp_code;
  assign bus_data_read = use_force ? force_data : mem[bus_addr[6:3]];

  always_comb begin
    wmask = '1;
    if (bus_size != SZ_D)
      wmask = ((64'd1 << (8 << bus_size)) - 64'd1)
              << {bus_addr[2:0], 3'b000};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (bus_valid && !bus_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (bus_valid && bus_ready && bus_req == REQ_WRITE)
      mem[bus_addr[6:3]] <= (mem[bus_addr[6:3]] & ~wmask)
                            | (bus_data_write & wmask);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
  end

  // monitor: scoreboard pop and bus activity counters
  int done_n = 0;
  int done_at = 0;
  int valid_n = 0;
  int hs_n = 0;
  int stab_bad = 0;
  bit pv = 1'b0;
  logic [130:0] prev_bus = '0;
  logic [63:0] last_bdw = '0;

  always @(negedge clk) begin
    exp_t e;
    if (lsu_done) begin
      done_n++;
      done_at = cyc;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected rdata=%h err=%b required no pulse",
                 lsu_rdata, lsu_err);
      end else begin
        e = sb.pop_front();
        if ({lsu_rdata, lsu_err} !== e) begin
          n_bad++;
          $display("FAIL resp_%0d rdata=%h err=%b required rdata=%h err=%b",
                   done_n, lsu_rdata, lsu_err, e.rdata, e.err);
        end
      end
    end
    if (bus_valid) begin
      valid_n++;
      last_bdw = bus_data_write;
      if (pv && {bus_addr, bus_size, bus_req, bus_data_write} != prev_bus)
        stab_bad++;
      prev_bus = {bus_addr, bus_size, bus_req, bus_data_write};
    end
    pv = bus_valid;
    if (bus_valid && bus_ready) hs_n++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic issue(
    input logic        we,
    input logic [1:0]  size,
    input logic        uns,
    input logic [63:0] addr,
    input logic [63:0] wdata,
    input bit          push,
    input logic [63:0] er,
    input logic [1:0]  ee
  );
    if (push) sb.push_back({er, ee});
    lsu_we = we;
    lsu_size = size;
    lsu_unsigned = uns;
    lsu_addr = addr;
    lsu_wdata = wdata;
    lsu_req_valid = 1'b1;
    acc = cyc;
    step(1);
    lsu_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 40 && done_n == d0; i++) step(1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !lsu_req_ready; i++) step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_bus_valid got=%b required=0", bus_valid);
    end
    n_cmp++;
    if ({bus_addr, bus_size, bus_req, bus_data_write} !== '0) begin
      n_bad++;
      $display("FAIL rst_bus_regs addr=%h size=%b req=%b wd=%h required all 0",
               bus_addr, bus_size, bus_req, bus_data_write);
    end
    n_cmp++;
    if ({lsu_done, lsu_rdata, lsu_err} !== '0) begin
      n_bad++;
      $display("FAIL rst_lsu_out done=%b rdata=%h err=%b required all 0",
               lsu_done, lsu_rdata, lsu_err);
    end
    n_cmp++;
    if (lsu_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready got=%b required=1", lsu_req_ready);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_store_mtimecmp();
    int d0, v0;
    lat = 0; use_force = 0; resp_code = 2'b00;
    wait_idle();
    d0 = done_n; v0 = valid_n;
    issue(1'b1, SZ_D, 1'b0, MTIMECMP_ADDR, 64'h100, 1, 64'h0, ERR_OK);
    wait_done(d0);
    n_cmp++;
    if (done_at - acc !== 2 || done_n - d0 !== 1) begin
      n_bad++;
      $display("FAIL st_latency got=%0d dones=%0d required=2 dones=1",
               done_at - acc, done_n - d0);
    end
    n_cmp++;
    if (valid_n - v0 !== 1) begin
      n_bad++;
      $display("FAIL st_valid_cycles got=%0d required=1", valid_n - v0);
    end
    n_cmp++;
    if (last_bdw !== 64'h100) begin
      n_bad++;
      $display("FAIL st_wdata got=%h required=%h", last_bdw, 64'h100);
    end
    wait_idle();
    d0 = done_n;
    issue(1'b0, SZ_D, 1'b0, MTIMECMP_ADDR, 64'h0, 1, 64'h100, ERR_OK);
    wait_done(d0);
    n_cmp++;
    if (done_at - acc !== 2 || done_n - d0 !== 1) begin
      n_bad++;
      $display("FAIL ld_latency got=%0d required=2", done_at - acc);
    end
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        u;
    logic [2:0]  off;
    logic [63:0] raw;
    logic [63:0] exp;
  } ld_vec_t;

  ld_vec_t ld_vec [7] = '{
    '{SZ_B, 1'b0, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80},
    '{SZ_B, 1'b1, 3'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080},
    '{SZ_H, 1'b0, 3'd2, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_8000},
    '{SZ_W, 1'b0, 3'd4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321},
    '{SZ_W, 1'b1, 3'd4, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321},
    '{SZ_H, 1'b1, 3'd6, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF},
    '{SZ_B, 1'b0, 3'd0, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_007F}
  };

  task automatic test_load_extend();
    int d0;
    lat = 0; use_force = 1;
    foreach (ld_vec[i]) begin
      wait_idle();
      force_data = ld_vec[i].raw;
      d0 = done_n;
      issue(1'b0, ld_vec[i].sz, ld_vec[i].u,
            64'h1000 + 64'(ld_vec[i].off), 64'h0,
            1, ld_vec[i].exp, ERR_OK);
      wait_done(d0);
    end
    use_force = 0;
  endtask

  task automatic test_store_lanes();
    int d0;
    lat = 0; use_force = 0;
    wait_idle();
    d0 = done_n;
    issue(1'b1, SZ_B, 1'b0, 64'h45, 64'hFFFF_FFFF_FFFF_FFAB, 1, 64'h0, ERR_OK);
    wait_done(d0);
    n_cmp++;
    if (last_bdw[47:40] !== 8'hAB) begin
      n_bad++;
      $display("FAIL lane_byte got=%h required byte 5 = ab", last_bdw);
    end
    wait_idle();
    d0 = done_n;
    issue(1'b1, SZ_H, 1'b0, 64'h42, 64'h0000_0000_0000_CAFE, 1, 64'h0, ERR_OK);
    wait_done(d0);
    n_cmp++;
    if (last_bdw !== 64'h0000_0000_CAFE_0000) begin
      n_bad++;
      $display("FAIL lane_half got=%h required=%h",
               last_bdw, 64'h0000_0000_CAFE_0000);
    end
    wait_idle();
    d0 = done_n;
    issue(1'b0, SZ_D, 1'b0, 64'h40, 64'h0, 1, 64'h0000_AB00_CAFE_0000, ERR_OK);
    wait_done(d0);
  endtask

  task automatic test_wait3();
    int d0, v0, s0;
    lat = 3; use_force = 0;
    wait_idle();
    d0 = done_n; v0 = valid_n; s0 = stab_bad;
    issue(1'b1, SZ_W, 1'b0, 64'h5C, 64'h1234_5678, 1, 64'h0, ERR_OK);
    wait_done(d0);
    n_cmp++;
    if (done_at - acc !== 5 || done_n - d0 !== 1) begin
      n_bad++;
      $display("FAIL w3_latency got=%0d required=5", done_at - acc);
    end
    n_cmp++;
    if (valid_n - v0 !== 4 || stab_bad - s0 !== 0) begin
      n_bad++;
      $display("FAIL w3_hold valid=%0d unstable=%0d required valid=4 unstable=0",
               valid_n - v0, stab_bad - s0);
    end
    n_cmp++;
    if ({bus_addr, bus_size, bus_req, last_bdw}
        !== {64'h5C, SZ_W, REQ_WRITE, 64'h1234_5678_0000_0000}) begin
      n_bad++;
      $display("FAIL w3_bus addr=%h size=%b req=%b wd=%h required 5c/10/1/1234567800000000",
               bus_addr, bus_size, bus_req, last_bdw);
    end
  endtask

  task automatic test_timeout();
    int d0, v0, h0;
    lat = 0; never = 1;
    wait_idle();
    d0 = done_n; v0 = valid_n; h0 = hs_n;
    issue(1'b0, SZ_D, 1'b0, 64'h80, 64'h0, 1, 64'h0, ERR_TMO);
    wait_done(d0);
    n_cmp++;
    if (done_at - acc !== 5 || valid_n - v0 !== 4 || hs_n - h0 !== 0) begin
      n_bad++;
      $display("FAIL tmo_abort lat=%0d valid=%0d hs=%0d required 5/4/0",
               done_at - acc, valid_n - v0, hs_n - h0);
    end
    never = 0; lat = 3; use_force = 1;
    force_data = 64'h1122_3344_5566_7788;
    wait_idle();
    d0 = done_n; h0 = hs_n;
    issue(1'b0, SZ_D, 1'b0, 64'h80, 64'h0, 1, 64'h1122_3344_5566_7788, ERR_OK);
    wait_done(d0);
    n_cmp++;
    if (done_at - acc !== 5 || hs_n - h0 !== 1) begin
      n_bad++;
      $display("FAIL tmo_race lat=%0d hs=%0d required 5/1",
               done_at - acc, hs_n - h0);
    end
    use_force = 0;
  endtask

  task automatic test_bus_error();
    int d0;
    lat = 1; use_force = 1; force_data = 64'hDEAD;
    resp_code = 2'b01;
    wait_idle();
    d0 = done_n;
    issue(1'b0, SZ_D, 1'b0, 64'h88, 64'h0, 1, 64'hDEAD, ERR_BUS);
    wait_done(d0);
    resp_code = 2'b10;
    wait_idle();
    d0 = done_n;
    issue(1'b0, SZ_D, 1'b0, 64'h88, 64'h0, 1, 64'hDEAD, ERR_BUS);
    wait_done(d0);
    resp_code = 2'b00; use_force = 0;
  endtask

  task automatic test_misaligned();
    int d0, v0;
    logic [1:0] szs [3] = '{SZ_H, SZ_W, SZ_D};
    logic [63:0] ads [3] = '{64'h101, 64'h102, 64'h104};
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      wait_idle();
      d0 = done_n; v0 = valid_n;
      issue(1'b0, szs[i], 1'b0, ads[i], 64'h0, 1, 64'h0, ERR_MIS);
      wait_done(d0);
      n_cmp++;
      if (done_at - acc !== 1 || valid_n - v0 !== 0) begin
        n_bad++;
        $display("FAIL mis_%0d lat=%0d valid=%0d required lat=1 valid=0",
                 i, done_at - acc, valid_n - v0);
      end
    end
  endtask

  task automatic test_flush();
    int d0, h0;
    lat = 2; use_force = 1; force_data = 64'h55;
    wait_idle();
    d0 = done_n; h0 = hs_n;
    issue(1'b0, SZ_D, 1'b0, 64'h90, 64'h0, 0, 64'h0, ERR_OK);
    lsu_flush = 1'b1;
    step(1);
    lsu_flush = 1'b0;
    wait_idle();
    step(2);
    n_cmp++;
    if (done_n - d0 !== 0 || hs_n - h0 !== 1) begin
      n_bad++;
      $display("FAIL flush_req dones=%0d hs=%0d required 0/1",
               done_n - d0, hs_n - h0);
    end
    lat = 0;
    d0 = done_n;
    issue(1'b0, SZ_D, 1'b0, 64'h90, 64'h0, 0, 64'h0, ERR_OK);
    @(posedge clk);
    #1;
    lsu_flush = 1'b1;
    step(1);
    lsu_flush = 1'b0;
    step(1);
    n_cmp++;
    if (done_n - d0 !== 0) begin
      n_bad++;
      $display("FAIL flush_resp dones=%0d required=0", done_n - d0);
    end
    wait_idle();
    d0 = done_n;
    lsu_flush = 1'b1;
    issue(1'b0, SZ_D, 1'b0, 64'h90, 64'h0, 1, 64'h55, ERR_OK);
    lsu_flush = 1'b0;
    wait_done(d0);
    n_cmp++;
    if (done_n - d0 !== 1 || done_at - acc !== 2) begin
      n_bad++;
      $display("FAIL flush_idle dones=%0d lat=%0d required 1/2",
               done_n - d0, done_at - acc);
    end
    use_force = 0;
  endtask

  task automatic test_async_rst();
    int d0;
    never = 1; lat = 0;
    wait_idle();
    d0 = done_n;
    issue(1'b0, SZ_D, 1'b0, 64'h98, 64'h0, 0, 64'h0, ERR_OK);
    n_cmp++;
    if (bus_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre valid=%b required=1", bus_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus_valid !== 1'b0 || lsu_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_now valid=%b ready=%b required 0/1",
               bus_valid, lsu_req_ready);
    end
    step(2);
    rst = 1'b0;
    never = 0;
    step(2);
    n_cmp++;
    if (lsu_req_ready !== 1'b1 || done_n - d0 !== 0) begin
      n_bad++;
      $display("FAIL arst_after ready=%b dones=%0d required 1/0",
               lsu_req_ready, done_n - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    lat = 0; use_force = 1; force_data = 64'h0123_4567_89AB_CDEF;
    wait_idle();
    d0 = done_n;
    issue(1'b0, SZ_D, 1'b0, 64'hA0, 64'h0, 1, 64'h0123_4567_89AB_CDEF, ERR_OK);
    n_cmp++;
    if (lsu_req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ready_req got=%b required=0", lsu_req_ready);
    end
    step(1);
    n_cmp++;
    if (lsu_req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ready_resp got=%b required=0", lsu_req_ready);
    end
    step(1);
    n_cmp++;
    if (lsu_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_idle got=%b required=1", lsu_req_ready);
    end
    issue(1'b0, SZ_B, 1'b1, 64'hA7, 64'h0, 1, 64'h01, ERR_OK);
    wait_done(d0 + 1);
    n_cmp++;
    if (done_n - d0 !== 2 || done_at - acc !== 2) begin
      n_bad++;
      $display("FAIL b2b_second dones=%0d lat=%0d required 2/2",
               done_n - d0, done_at - acc);
    end
    use_force = 0;
  endtask

  initial begin
    test_reset();
    test_store_mtimecmp();
    test_load_extend();
    test_store_lanes();
    test_wait3();
    test_timeout();
    test_bus_error();
    test_misaligned();
    test_flush();
    test_async_rst();
    test_back_to_back();
    step(3);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_drain left=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1);
  end

endmodule
